// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the instruction loader and the control-unit decoder.
// Holds the request kind codes, DP cmd codes, Op field values, LDR/STR funct
// constants and the loader FSM state enum.
package cpu_isa_pkg;

    typedef enum logic [2:0] {
        KindDpImm = 3'd0,
        KindDpReg = 3'd1,
        KindLdr   = 3'd2,
        KindStr   = 3'd3,
        KindB     = 3'd4
    } kind_e;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdOrr = 4'b1100;

    localparam logic [1:0] OpDp     = 2'b00;
    localparam logic [1:0] OpMem    = 2'b01;
    localparam logic [1:0] OpBranch = 2'b10;

    // Bits [25:20] of the memory instructions: I=0, P=1, U=1, B=0, W=0, L.
    localparam logic [5:0] FunctLdr = 6'b011001;
    localparam logic [5:0] FunctStr = 6'b011000;

    // Bits [25:24] of a plain branch (no link).
    localparam logic [1:0] FunctB = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StFull  = 2'd2
    } loader_state_e;

    function automatic logic is_dp_cmd(input logic [3:0] cmd);
        logic ok;
        case (cmd)
            CmdAnd, CmdSub, CmdAdd, CmdOrr: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus of the instruction loader.
//   master: drives the request fields, observes in_ready and the write bus.
//   slave : the loader; accepts requests and drives the write bus.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        kind;
    logic [3:0]        cmd;
    logic              s_bit;
    logic [3:0]        cond;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [3:0]        rm;
    logic [11:0]       imm12;
    logic [23:0]       imm24;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, kind, cmd, s_bit, cond, rn, rd, rm, imm12, imm24,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, kind, cmd, s_bit, cond, rn, rd, rm, imm12, imm24,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Combinational formation of one 32-bit machine word from request fields.
//   in : kind, cmd, s_bit, cond, rn, rd, rm, imm12, imm24
//   out: word  - encoded instruction (meaningful only when legal)
//        legal - request kind/cmd combination is encodable
module instr_word_encoder
    import cpu_isa_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [3:0]  cmd,
    input  logic        s_bit,
    input  logic [3:0]  cond,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [11:0] imm12,
    input  logic [23:0] imm24,
    output logic [31:0] word,
    output logic        legal
);
    kind_e kind_dec;
    assign kind_dec = kind_e'(kind);

    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        case (kind_dec)
            KindDpImm: begin
                word  = {cond, OpDp, 1'b1, cmd, s_bit, rn, rd, imm12};
                legal = is_dp_cmd(cmd);
            end
            KindDpReg: begin
                word  = {cond, OpDp, 1'b0, cmd, s_bit, rn, rd, 8'h00, rm};
                legal = is_dp_cmd(cmd);
            end
            KindLdr: begin
                word  = {cond, OpMem, FunctLdr, rn, rd, imm12};
                legal = 1'b1;
            end
            KindStr: begin
                word  = {cond, OpMem, FunctStr, rn, rd, imm12};
                legal = 1'b1;
            end
            KindB: begin
                word  = {cond, OpBranch, FunctB, imm24};
                legal = 1'b1;
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests and writes them to consecutive words of an
// instruction memory, one word every two cycles, stopping when memory is full.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous restart of address, count, error and full
//   bus        : request handshake + memory write bus (slave side)
//   count      : words written since reset/clear
//   full       : memory exhausted, no further requests accepted
//   error      : sticky, an illegal request was consumed
module instr_encoder_loader
    import cpu_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   error
);
    localparam int unsigned       Depth      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] BaseAddr   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   DepthCount = (ADDR_W + 1)'(Depth);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       wdata_q;
    logic              error_q;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;
    logic        last_write;

    instr_word_encoder u_encoder (
        .kind  (bus.kind),
        .cmd   (bus.cmd),
        .s_bit (bus.s_bit),
        .cond  (bus.cond),
        .rn    (bus.rn),
        .rd    (bus.rd),
        .rm    (bus.rm),
        .imm12 (bus.imm12),
        .imm24 (bus.imm24),
        .word  (enc_word),
        .legal (enc_legal)
    );

    // A coincident clear drops the request, so it is never consumed.
    assign accept = (state_q == StIdle) && bus.in_valid && !clear;

    // Either limit ends loading; the address check covers a nonzero base.
    assign last_write = ((count_q + 1'b1) == DepthCount) || (addr_q == LastAddr);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && enc_legal) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // The write itself always completes; clear only redirects.
                if (clear) begin
                    state_d = StIdle;
                end else if (last_write) begin
                    state_d = StFull;
                end else begin
                    state_d = StIdle;
                end
            end
            StFull: begin
                if (clear) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= BaseAddr;
            count_q <= '0;
            wdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && enc_legal) begin
                wdata_q <= enc_word;
            end
            if (clear) begin
                addr_q  <= BaseAddr;
                count_q <= '0;
                error_q <= 1'b0;
            end else if (state_q == StWrite) begin
                count_q <= count_q + 1'b1;
                // Hold at the last address instead of wrapping.
                if (!last_write) begin
                    addr_q <= addr_q + 1'b1;
                end
            end else if (accept && !enc_legal) begin
                error_q <= 1'b1;
            end
        end
    end

    // in_ready is gated by reset so it is low for the whole reset pulse.
    assign bus.in_ready  = (state_q == StIdle) && !reset;
    assign bus.mem_we    = (state_q == StWrite);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign count         = count_q;
    assign full          = (state_q == StFull);
    assign error         = error_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          error;

    int total = 0;
    int bad   = 0;

    instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

    instr_encoder_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus),
        .count (count),
        .full  (full),
        .error (error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] k, input logic [3:0] c, input logic s,
                           input logic [3:0] cd, input logic [3:0] n, input logic [3:0] d,
                           input logic [3:0] m, input logic [11:0] i12, input logic [23:0] i24);
        bus.kind  = k;
        bus.cmd   = c;
        bus.s_bit = s;
        bus.cond  = cd;
        bus.rn    = n;
        bus.rd    = d;
        bus.rm    = m;
        bus.imm12 = i12;
        bus.imm24 = i24;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 10 && bus.in_ready !== 1'b1; i++) tick();
        if (bus.in_ready !== 1'b1) check_val({tag, "_rdy"}, {31'h0, bus.in_ready}, 32'h1);
    endtask

    // Presents the current request for one cycle and checks the resulting write.
    task automatic write_word(input string tag, input logic [31:0] exp_word,
                              input logic [AW-1:0] exp_addr, input logic [AW:0] exp_cnt);
        wait_ready(tag);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_val({tag, "_we"}, {31'h0, bus.mem_we}, 32'h1);
        check_val({tag, "_addr"}, {30'h0, bus.mem_addr}, {30'h0, exp_addr});
        check_val({tag, "_wdata"}, bus.mem_wdata, exp_word);
        check_val({tag, "_busy"}, {31'h0, bus.in_ready}, 32'h0);
        tick();
        check_val({tag, "_we_off"}, {31'h0, bus.mem_we}, 32'h0);
        check_val({tag, "_hold"}, bus.mem_wdata, exp_word);
        check_val({tag, "_count"}, {29'h0, count}, {29'h0, exp_cnt});
    endtask

    task automatic illegal_req(input string tag, input logic [AW:0] exp_cnt);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_val({tag, "_nowe"}, {31'h0, bus.mem_we}, 32'h0);
        check_val({tag, "_err"}, {31'h0, error}, 32'h1);
        check_val({tag, "_count"}, {29'h0, count}, {29'h0, exp_cnt});
        check_val({tag, "_rdy"}, {31'h0, bus.in_ready}, 32'h1);
        tick();
        check_val({tag, "_nowe2"}, {31'h0, bus.mem_we}, 32'h0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        set_req(3'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 12'd0, 24'd0);

        // Reset state while reset is held
        #12;
        check_val("rst_ready", {31'h0, bus.in_ready}, 32'h0);
        check_val("rst_we", {31'h0, bus.mem_we}, 32'h0);
        check_val("rst_addr", {30'h0, bus.mem_addr}, 32'h0);
        check_val("rst_wdata", bus.mem_wdata, 32'h0);
        check_val("rst_count", {29'h0, count}, 32'h0);
        check_val("rst_full", {31'h0, full}, 32'h0);
        check_val("rst_err", {31'h0, error}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_val("rel_ready", {31'h0, bus.in_ready}, 32'h1);

        // DP_IMM ADD, DP_REG SUB with S
        set_req(3'd0, 4'b0100, 1'b0, 4'hE, 4'd2, 4'd1, 4'd0, 12'h005, 24'h0);
        write_word("dpimm", 32'hE2821005, 2'd0, 3'd1);
        set_req(3'd1, 4'b0010, 1'b1, 4'hE, 4'd4, 4'd3, 4'd5, 12'h0, 24'h0);
        write_word("dpreg", 32'hE0543005, 2'd1, 3'd2);
        pulse_clear();
        check_val("clr_count", {29'h0, count}, 32'h0);

        // LDR, STR, B
        set_req(3'd2, 4'd0, 1'b0, 4'hE, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0);
        write_word("ldr", 32'hE5910008, 2'd0, 3'd1);
        set_req(3'd3, 4'd0, 1'b0, 4'hE, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0);
        write_word("str", 32'hE5810008, 2'd1, 3'd2);
        set_req(3'd4, 4'd0, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 12'h0, 24'hFFFFFE);
        write_word("br", 32'hEAFFFFFE, 2'd2, 3'd3);

        // Illegal kind and illegal DP cmd
        set_req(3'd6, 4'd0, 1'b0, 4'hE, 4'd1, 4'd1, 4'd1, 12'h1, 24'h1);
        illegal_req("ill_kind", 3'd3);
        set_req(3'd0, 4'b1111, 1'b0, 4'hE, 4'd1, 4'd1, 4'd1, 12'h1, 24'h1);
        illegal_req("ill_cmd", 3'd3);

        // Last word: ORR imm with cond=0, lands in FULL; error stays sticky
        set_req(3'd0, 4'b1100, 1'b1, 4'h0, 4'd7, 4'd8, 4'd0, 12'hABC, 24'h0);
        write_word("last", 32'h03978ABC, 2'd3, 3'd4);
        check_val("full_set", {31'h0, full}, 32'h1);
        check_val("full_rdy", {31'h0, bus.in_ready}, 32'h0);
        check_val("err_sticky", {31'h0, error}, 32'h1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("full_nowe", {31'h0, bus.mem_we}, 32'h0);
            check_val("full_count", {29'h0, count}, 32'h4);
        end
        bus.in_valid = 1'b0;
        pulse_clear();
        check_val("fclr_full", {31'h0, full}, 32'h0);
        check_val("fclr_err", {31'h0, error}, 32'h0);
        check_val("fclr_rdy", {31'h0, bus.in_ready}, 32'h1);
        check_val("fclr_count", {29'h0, count}, 32'h0);

        // Clear coincident with acceptance drops the request
        set_req(3'd2, 4'd0, 1'b0, 4'hE, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0);
        bus.in_valid = 1'b1;
        clear = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        clear = 1'b0;
        check_val("clracc_we", {31'h0, bus.mem_we}, 32'h0);
        check_val("clracc_cnt", {29'h0, count}, 32'h0);
        tick();
        check_val("clracc_we2", {31'h0, bus.mem_we}, 32'h0);

        // Reset pulsed during WRITE
        write_word("pre_rst", 32'hE5910008, 2'd0, 3'd1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_val("wrst_we_on", {31'h0, bus.mem_we}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_val("wrst_we", {31'h0, bus.mem_we}, 32'h0);
        check_val("wrst_count", {29'h0, count}, 32'h0);
        check_val("wrst_addr", {30'h0, bus.mem_addr}, 32'h0);
        check_val("wrst_rdy", {31'h0, bus.in_ready}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check_val("wrst_rel", {31'h0, bus.in_ready}, 32'h1);

        // Back-to-back: writes every other cycle at 0..3, then FULL
        set_req(3'd3, 4'd0, 1'b0, 4'hE, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i % 2 == 0 && i <= 6) begin
                check_val("b2b_we", {31'h0, bus.mem_we}, 32'h1);
                check_val("b2b_addr", {30'h0, bus.mem_addr}, i / 2);
            end else begin
                check_val("b2b_gap", {31'h0, bus.mem_we}, 32'h0);
            end
        end
        bus.in_valid = 1'b0;
        check_val("b2b_full", {31'h0, full}, 32'h1);
        check_val("b2b_rdy", {31'h0, bus.in_ready}, 32'h0);
        check_val("b2b_count", {29'h0, count}, 32'h4);
        pulse_clear();
        set_req(3'd4, 4'd0, 1'b0, 4'h1, 4'd0, 4'd0, 4'd0, 12'h0, 24'h000010);
        write_word("after_clr", 32'h1A000010, 2'd0, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameter ADDR_W, default 6, instruction-memory word-address width; depth = 2**ADDR_W.
REQ-002 Parameter BASE_ADDR, default 0, first word address written after reset or clear.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 clear  input  1  synchronous restart: address to BASE_ADDR, count to 0, error and full cleared.
REQ-006 in_valid  input  1  an instruction request is presented.
REQ-007 in_ready  output  1  the block can accept a request this cycle.
REQ-008 kind  input  3  instruction class: DP_IMM=0, DP_REG=1, LDR=2, STR=3, B=4; values 5-7 are illegal.
REQ-009 cmd  input  4  DP operation: ADD=0100, SUB=0010, AND=0000, ORR=1100; all other values are illegal for DP kinds.
REQ-010 s_bit  input  1  set-flags bit for DP kinds; ignored for other kinds.
REQ-011 cond  input  4  condition field, placed in bits [31:28].
REQ-012 rn, rd, rm  input  4 each  register fields.
REQ-013 imm12  input  12  DP_IMM Src2 ({rot4, imm8}) or LDR/STR offset.
REQ-014 imm24  input  24  branch word offset, two's complement.
REQ-015 mem_we  output  1  instruction-memory write strobe.
REQ-016 mem_addr  output  ADDR_W  word address of the write.
REQ-017 mem_wdata  output  32  encoded machine word.
REQ-018 count  output  ADDR_W+1  number of words written since reset or clear.
REQ-019 full  output  1  memory exhausted.
REQ-020 error  output  1  sticky flag: an illegal request was seen.

Function
REQ-021 The block SHALL implement FSM states IDLE, WRITE and FULL.
REQ-022 In IDLE: in_ready=1; if in_valid is high and the request is legal, the encoded word and address SHALL be registered and the FSM SHALL go to WRITE.
REQ-023 In IDLE, an illegal request SHALL be consumed: set error, perform no write, stay in IDLE.
REQ-024 In WRITE: mem_we=1 for exactly one cycle with registered addr/wdata; in_ready=0; the address SHALL increment and count SHALL increment.
REQ-025 After WRITE, the FSM SHALL go to IDLE, or to FULL if count equals the depth.
REQ-026 Latency: request accepted at edge N, mem_we high during cycle N+1; throughput is one word per 2 cycles.
REQ-027 In FULL: full=1, in_ready=0, no writes; only clear or reset SHALL leave this state (to IDLE).
REQ-028 The address SHALL never wrap; a write to the last address SHALL lead to FULL.
REQ-029 Encoding, bits [27:26]: Op is 00 for DP, 01 for LDR/STR, 10 for B.
REQ-030 DP encoding: [25]=1 for DP_IMM and 0 for DP_REG; [24:21]=cmd; [20]=s_bit; [19:16]=rn; [15:12]=rd; [11:0]=imm12 for DP_IMM, or {8'b0, rm} for DP_REG.
REQ-031 LDR/STR encoding: [25:20]=011001 for LDR and 011000 for STR; [19:16]=rn; [15:12]=rd; [11:0]=imm12.
REQ-032 B encoding: [25:24]=10; [23:0]=imm24 unmodified.
REQ-033 If clear is asserted together with an in_valid acceptance, clear SHALL win and the request SHALL be dropped.
REQ-034 If clear is asserted during WRITE, the write cycle SHALL complete; count and address then restart from BASE_ADDR.
REQ-035 mem_wdata SHALL hold its value outside of WRITE cycles; mem_we SHALL be low outside WRITE.

Reset
REQ-036 On reset, all outputs and state SHALL take these values immediately: state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, error=0.
REQ-037 in_ready SHALL be 0 while reset is high and 1 on the first cycle after reset release.
REQ-038 Reset asserted during WRITE SHALL abort the write: mem_we drops asynchronously.

Structure
REQ-039 The kind codes, cmd codes, Op values, LDR/STR funct constants and the FSM state enum SHALL live in a shared package, cpu_isa_pkg, which the control-unit decoder also imports.
REQ-040 The combinational word formation SHALL be one sub-module, instr_word_encoder (fields in, 32-bit word and legal flag out); the top level holds the FSM, counters and registers.

Verification
REQ-041 DP_IMM, cmd=ADD, cond=E, rn=2, rd=1, imm12=005 -> one mem_we pulse at addr 0 with wdata 0xE2821005; count=1.
REQ-042 DP_REG, cmd=SUB, s_bit=1, rn=4, rd=3, rm=5 -> wdata 0xE0543005; LDR rn=1, rd=0, imm12=008 -> 0xE5910008; STR with the same fields -> 0xE5810008.
REQ-043 B, cond=E, imm24=FFFFFE -> wdata 0xEAFFFFFE.
REQ-044 kind=6 or DP cmd=1111 -> no mem_we, error=1 and sticky, count unchanged; subsequent legal requests still write.
REQ-045 ADDR_W=2, back-to-back valid requests -> writes at addrs 0-3 two cycles apart, then full=1, in_ready=0; clear -> IDLE, next write at addr 0.
REQ-046 Reset pulsed in the WRITE cycle -> mem_we low immediately, count=0; clear coincident with acceptance -> no write.
